// File: rtl/switch_cell_fetch.sv
// Frame descriptor driven cell fetcher: pointer FIFO -> data FIFO -> core.
// Build option DROP_ZERO_PORTMAP_EN discards frames whose portmap is 0.
module switch_cell_fetch #(
    parameter int DATA_W = 128,
    parameter int PTR_W  = 16,
    parameter int LEN_W  = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ptr_fifo_empty,
    output logic              ptr_fifo_rd,
    input  logic [PTR_W-1:0]  ptr_fifo_din,
    input  logic              data_fifo_empty,
    output logic              data_fifo_rd,
    input  logic [DATA_W-1:0] data_fifo_din,
    output logic [DATA_W-1:0] o_cell_data,
    output logic              o_cell_valid,
    input  logic              o_cell_ready,
    output logic              o_cell_sop,
    output logic              o_cell_eop,
    output logic [3:0]        o_cell_portmap,
    output logic              o_len_err,
    output logic              o_drop
);
    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        FETCH
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [LEN_W+1:0] r_cells;
    logic [3:0]       r_portmap;
    logic             r_drop_frame;
    logic [8:0]       r_issued;
    logic [8:0]       r_returned;
    logic             r_ret_vld;
    logic             r_ret_push;
    logic [3:0]       r_ret_pm;

    logic [1:0][DATA_W-1:0] r_buf_data;
    logic [1:0][3:0]        r_buf_pm;
    logic [1:0]             r_buf_sop;
    logic [1:0]             r_buf_eop;
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_occ;

    logic [LEN_W-1:0] w_len;
    logic [LEN_W+1:0] w_cells;
    logic [3:0]       w_pm;
    logic             w_drop_desc;
    logic             w_push;
    logic             w_pop;
    logic             w_credit;
    logic             w_want;
    logic             w_ptr_rd;
    logic             w_data_rd;
    logic             w_ret_sop;
    logic             w_ret_eop;
    logic             w_unused_bits;

    assign w_len   = ptr_fifo_din[LEN_W-1:0];
    assign w_cells = {w_len, 2'b00};
    assign w_pm    = ptr_fifo_din[11:8];
    assign w_unused_bits = ^{ptr_fifo_din[PTR_W-1:12],
                             ptr_fifo_din[7:LEN_W]};

`ifdef DROP_ZERO_PORTMAP_EN
    assign w_drop_desc = (w_pm == 4'd0);
`else
    assign w_drop_desc = 1'b0;
`endif

    assign w_pop  = o_cell_valid & o_cell_ready;
    assign w_push = r_ret_vld & r_ret_push;

    // A pushable read in flight already owns a buffer slot.
    assign w_credit = ({1'b0, r_occ} + {2'b00, w_push})
                      < (3'd2 + {2'b00, w_pop});

    assign w_want = !data_fifo_empty
                  && (r_issued < {1'b0, r_cells})
                  && (r_drop_frame || w_credit);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_rd    = 1'b0;
        w_data_rd   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!ptr_fifo_empty) begin
                    w_ptr_rd    = 1'b1;
                    w_state_nxt = LATCH;
                end
            end
            LATCH: begin
                w_state_nxt = (w_len == '0) ? IDLE : FETCH;
            end
            FETCH: begin
                w_data_rd = w_want;
                if ((r_issued + {8'd0, w_data_rd})
                    == {1'b0, r_cells})
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Strobes stay quiet while reset holds the FSM in IDLE.
    assign ptr_fifo_rd  = w_ptr_rd & rstn;
    assign data_fifo_rd = w_data_rd;

    assign o_len_err = (r_state == LATCH) && (w_len == '0);
    assign o_drop    = (r_state == LATCH) && (w_len != '0)
                     && w_drop_desc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_cells      <= '0;
            r_portmap    <= '0;
            r_drop_frame <= 1'b0;
            r_issued     <= '0;
            r_returned   <= '0;
            r_ret_vld    <= 1'b0;
            r_ret_push   <= 1'b0;
            r_ret_pm     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ret_vld  <= w_data_rd;
            r_ret_push <= w_data_rd & !r_drop_frame;
            r_ret_pm   <= r_portmap;
            if (r_state == LATCH) begin
                r_cells      <= w_cells;
                r_portmap    <= w_pm;
                r_drop_frame <= w_drop_desc;
                r_issued     <= '0;
                r_returned   <= '0;
            end else begin
                if (w_data_rd)
                    r_issued <= r_issued + 9'd1;
                if (r_ret_vld)
                    r_returned <= r_returned + 9'd1;
            end
        end
    end

    assign w_ret_sop = (r_returned == 9'd0);
    assign w_ret_eop = (r_returned == ({1'b0, r_cells} - 9'd1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_buf_data <= '0;
            r_buf_pm   <= '0;
            r_buf_sop  <= '0;
            r_buf_eop  <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_occ      <= '0;
        end else begin
            if (w_push) begin
                r_buf_data[r_wr_ptr] <= data_fifo_din;
                r_buf_pm[r_wr_ptr]   <= r_ret_pm;
                r_buf_sop[r_wr_ptr]  <= w_ret_sop;
                r_buf_eop[r_wr_ptr]  <= w_ret_eop;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            unique case (1'b1)
                w_push && !w_pop: r_occ <= r_occ + 2'd1;
                w_pop && !w_push: r_occ <= r_occ - 2'd1;
                default: ;
            endcase
        end
    end

    assign o_cell_valid   = (r_occ != 2'd0);
    assign o_cell_data    = o_cell_valid ? r_buf_data[r_rd_ptr] : '0;
    assign o_cell_sop     = o_cell_valid & r_buf_sop[r_rd_ptr];
    assign o_cell_eop     = o_cell_valid & r_buf_eop[r_rd_ptr];
    assign o_cell_portmap = o_cell_valid ? r_buf_pm[r_rd_ptr] : 4'd0;

endmodule

// File: tb/tb_switch_cell_fetch.sv
// Bench for switch_cell_fetch: FIFO models, monitor, and a frame-level
// reference that expands each descriptor into its expected tagged cells.
module tb_switch_cell_fetch;
    localparam int DW  = 128;
    localparam int MEM = 4096;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [3:0]    pm;
    } cell_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          ptr_fifo_empty;
    logic          ptr_fifo_rd;
    logic [15:0]   ptr_fifo_din = '0;
    logic          data_fifo_empty;
    logic          data_fifo_rd;
    logic [DW-1:0] data_fifo_din = '0;
    logic [DW-1:0] o_cell_data;
    logic          o_cell_valid;
    logic          o_cell_ready = 1'b0;
    logic          o_cell_sop;
    logic          o_cell_eop;
    logic [3:0]    o_cell_portmap;
    logic          o_len_err;
    logic          o_drop;

    switch_cell_fetch dut (
        .clk             (clk),
        .rstn            (rstn),
        .ptr_fifo_empty  (ptr_fifo_empty),
        .ptr_fifo_rd     (ptr_fifo_rd),
        .ptr_fifo_din    (ptr_fifo_din),
        .data_fifo_empty (data_fifo_empty),
        .data_fifo_rd    (data_fifo_rd),
        .data_fifo_din   (data_fifo_din),
        .o_cell_data     (o_cell_data),
        .o_cell_valid    (o_cell_valid),
        .o_cell_ready    (o_cell_ready),
        .o_cell_sop      (o_cell_sop),
        .o_cell_eop      (o_cell_eop),
        .o_cell_portmap  (o_cell_portmap),
        .o_len_err       (o_len_err),
        .o_drop          (o_drop)
    );

    always #5 clk = ~clk;

    // FIFO models with one-clock read latency
    logic [15:0]   p_mem [MEM];
    logic [DW-1:0] d_mem [MEM];
    int p_wr = 0, p_rd = 0, d_wr = 0, d_rd = 0;
    int bad_prd = 0, bad_drd = 0;
    logic flush = 1'b0;

    assign ptr_fifo_empty  = (p_rd == p_wr);
    assign data_fifo_empty = (d_rd == d_wr);

    always @(posedge clk) begin
        if (flush) begin
            p_rd <= p_wr;
            d_rd <= d_wr;
        end else begin
            if (ptr_fifo_rd) begin
                if (p_rd == p_wr) bad_prd <= bad_prd + 1;
                else begin
                    ptr_fifo_din <= p_mem[p_rd % MEM];
                    p_rd <= p_rd + 1;
                end
            end
            if (data_fifo_rd) begin
                if (d_rd == d_wr) bad_drd <= bad_drd + 1;
                else begin
                    data_fifo_din <= d_mem[d_rd % MEM];
                    d_rd <= d_rd + 1;
                end
            end
        end
    end

    // Monitor: records accepted cells and event counts mid-cycle
    cell_t obs [$];
    int    obs_cyc [$];
    int    cyc = 0, n_lerr = 0, n_drop = 0, n_drd = 0, n_acc = 0;
    int    n_unstable = 0;
    cell_t cur, held;
    logic  held_v = 1'b0;

    always_comb begin
        cur      = '0;
        cur.data = o_cell_data;
        cur.sop  = o_cell_sop;
        cur.eop  = o_cell_eop;
        cur.pm   = o_cell_portmap;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rstn) begin
            if (o_len_err) n_lerr = n_lerr + 1;
            if (o_drop) n_drop = n_drop + 1;
            if (data_fifo_rd) n_drd = n_drd + 1;
            if (held_v && (!o_cell_valid || cur != held))
                n_unstable = n_unstable + 1;
            if (o_cell_valid && o_cell_ready) begin
                obs.push_back(cur);
                obs_cyc.push_back(cyc);
                n_acc = n_acc + 1;
            end
            held_v = o_cell_valid && !o_cell_ready;
            held   = cur;
        end else begin
            held_v = 1'b0;
        end
    end

    // Reference model
    cell_t         exp_q [$];
    logic [DW-1:0] pend [$];
    int exp_lerr = 0, exp_drop = 0, exp_rd = 0;
    int checks = 0, errors = 0, oi = 0;

    task automatic send_frame(input logic [15:0] d, input int hold);
        int n;
        logic dropf;
        logic [DW-1:0] c;
        cell_t e;
        n = int'(d[5:0]) * 4;
        dropf = 1'b0;
`ifdef DROP_ZERO_PORTMAP_EN
        dropf = (d[11:8] == 4'd0) && (n != 0);
`endif
        if (n == 0) exp_lerr++;
        if (dropf) exp_drop++;
        exp_rd += n;
        for (int i = 0; i < n; i++) begin
            c = {$urandom, $urandom, $urandom, $urandom};
            e.data = c;
            e.sop  = (i == 0);
            e.eop  = (i == n - 1);
            e.pm   = d[11:8];
            if (!dropf) exp_q.push_back(e);
            if (i < n - hold && pend.size() == 0) begin
                d_mem[d_wr % MEM] = c;
                d_wr++;
            end else begin
                pend.push_back(c);
            end
        end
        p_mem[p_wr % MEM] = d;
        p_wr++;
    endtask

    task automatic release_one();
        if (pend.size() > 0) begin
            d_mem[d_wr % MEM] = pend.pop_front();
            d_wr++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        o_cell_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (o_cell_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", o_cell_valid);
        end
        checks++;
        if (o_cell_data !== '0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", o_cell_data);
        end
        checks++;
        if ({o_cell_sop, o_cell_eop, o_cell_portmap} !== 6'd0) begin
            errors++;
            $display("FAIL reset_tags got %b%b%h want 000",
                     o_cell_sop, o_cell_eop, o_cell_portmap);
        end
        checks++;
        if ({ptr_fifo_rd, data_fifo_rd, o_len_err, o_drop} !== 4'd0) begin
            errors++;
            $display("FAIL reset_strobes got %b%b%b%b want 0000",
                     ptr_fifo_rd, data_fifo_rd, o_len_err, o_drop);
        end
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int oi0, d0, er0, need;
        cell_t e;
        oi0 = oi; d0 = n_drd; er0 = exp_rd;
        o_cell_ready = 1'b1;
        send_frame(16'h0301, 0);
        need = exp_q.size();
        for (int t = 0; t < 200; t++) begin
            if (obs.size() >= oi + need) break;
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (obs.size() != oi + need) begin
            errors++;
            $display("FAIL single_count got %0d want %0d",
                     obs.size() - oi, need);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (oi >= obs.size()) begin
                errors++;
                $display("FAIL single_missing cell %0d", oi - oi0);
            end else if (obs[oi] !== e) begin
                errors++;
                $display("FAIL single_cell%0d got %h want %h",
                         oi - oi0, obs[oi], e);
            end
            oi++;
        end
        checks++;
        if (obs_cyc.size() >= oi0 + 4 &&
            obs_cyc[oi0 + 3] - obs_cyc[oi0] != 3) begin
            errors++;
            $display("FAIL single_consecutive got span %0d want 3",
                     obs_cyc[oi0 + 3] - obs_cyc[oi0]);
        end
        checks++;
        if (n_drd - d0 != exp_rd - er0) begin
            errors++;
            $display("FAIL single_reads got %0d want %0d",
                     n_drd - d0, exp_rd - er0);
        end
    endtask

    task automatic test_backpressure();
        int oi0, d0, a0, u0, er0, need, ovf;
        cell_t e;
        oi0 = oi; d0 = n_drd; a0 = n_acc; u0 = n_unstable;
        er0 = exp_rd; ovf = 0;
        send_frame(16'h0301, 0);
        send_frame(16'h0c03, 0);
        need = exp_q.size();
        for (int t = 0; t < 800; t++) begin
            o_cell_ready = (t % 3 == 0) ||
                           (t >= 30 && $urandom_range(0, 1) == 1);
            @(posedge clk); #1;
            if ((n_drd - d0) - (n_acc - a0) > 2) ovf++;
            if (obs.size() >= oi + need) break;
        end
        o_cell_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (obs.size() != oi + need) begin
            errors++;
            $display("FAIL bp_count got %0d want %0d",
                     obs.size() - oi, need);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (oi >= obs.size()) begin
                errors++;
                $display("FAIL bp_missing cell %0d", oi - oi0);
            end else if (obs[oi] !== e) begin
                errors++;
                $display("FAIL bp_cell%0d got %h want %h",
                         oi - oi0, obs[oi], e);
            end
            oi++;
        end
        checks++;
        if (ovf != 0) begin
            errors++;
            $display("FAIL bp_occupancy got %0d overflows want 0", ovf);
        end
        checks++;
        if (n_unstable != u0) begin
            errors++;
            $display("FAIL bp_stable got %0d changes want 0",
                     n_unstable - u0);
        end
        checks++;
        if (n_drd - d0 != exp_rd - er0) begin
            errors++;
            $display("FAIL bp_reads got %0d want %0d",
                     n_drd - d0, exp_rd - er0);
        end
    endtask

    task automatic test_back_to_back();
        int oi0, need, gap;
        cell_t e;
        oi0 = oi;
        o_cell_ready = 1'b1;
        send_frame(16'h0101, 0);
        send_frame(16'h0802, 0);
        need = exp_q.size();
        for (int t = 0; t < 300; t++) begin
            if (obs.size() >= oi + need) break;
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (obs.size() != oi + need) begin
            errors++;
            $display("FAIL b2b_count got %0d want %0d",
                     obs.size() - oi, need);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (oi >= obs.size()) begin
                errors++;
                $display("FAIL b2b_missing cell %0d", oi - oi0);
            end else if (obs[oi] !== e) begin
                errors++;
                $display("FAIL b2b_cell%0d got %h want %h",
                         oi - oi0, obs[oi], e);
            end
            oi++;
        end
        checks++;
        if (obs_cyc.size() >= oi0 + 5) begin
            gap = obs_cyc[oi0 + 4] - obs_cyc[oi0 + 3] - 1;
            if (gap > 2) begin
                errors++;
                $display("FAIL b2b_gap got %0d idle clks want <=2", gap);
            end
        end else begin
            errors++;
            $display("FAIL b2b_gap got no second frame want <=2");
        end
    endtask

    task automatic test_len_err();
        int oi0, d0, l0, er0, el0, need;
        cell_t e;
        oi0 = oi; d0 = n_drd; l0 = n_lerr; er0 = exp_rd; el0 = exp_lerr;
        o_cell_ready = 1'b1;
        send_frame(16'h0500, 0);
        send_frame(16'h0201, 0);
        need = exp_q.size();
        for (int t = 0; t < 300; t++) begin
            if (obs.size() >= oi + need) break;
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (obs.size() != oi + need) begin
            errors++;
            $display("FAIL lerr_count got %0d want %0d",
                     obs.size() - oi, need);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (oi >= obs.size()) begin
                errors++;
                $display("FAIL lerr_missing cell %0d", oi - oi0);
            end else if (obs[oi] !== e) begin
                errors++;
                $display("FAIL lerr_cell%0d got %h want %h",
                         oi - oi0, obs[oi], e);
            end
            oi++;
        end
        checks++;
        if (n_lerr - l0 != exp_lerr - el0) begin
            errors++;
            $display("FAIL lerr_pulses got %0d want %0d",
                     n_lerr - l0, exp_lerr - el0);
        end
        checks++;
        if (n_drd - d0 != exp_rd - er0) begin
            errors++;
            $display("FAIL lerr_reads got %0d want %0d",
                     n_drd - d0, exp_rd - er0);
        end
    endtask

    task automatic test_stall();
        int oi0, d0, need;
        cell_t e;
        oi0 = oi; d0 = n_drd;
        o_cell_ready = 1'b1;
        send_frame(16'h0701, 2);
        need = exp_q.size();
        for (int t = 0; t < 100; t++) begin
            if (d_rd == d_wr) break;
            @(posedge clk); #1;
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (obs.size() - oi != 2 || n_drd - d0 != 2) begin
            errors++;
            $display("FAIL stall_partial got %0d cells %0d reads want 2 2",
                     obs.size() - oi, n_drd - d0);
        end
        while (pend.size() > 0) release_one();
        for (int t = 0; t < 100; t++) begin
            if (obs.size() >= oi + need) break;
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (obs.size() != oi + need) begin
            errors++;
            $display("FAIL stall_count got %0d want %0d",
                     obs.size() - oi, need);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (oi >= obs.size()) begin
                errors++;
                $display("FAIL stall_missing cell %0d", oi - oi0);
            end else if (obs[oi] !== e) begin
                errors++;
                $display("FAIL stall_cell%0d got %h want %h",
                         oi - oi0, obs[oi], e);
            end
            oi++;
        end
    endtask

    task automatic test_zero_portmap();
        int oi0, d0, dr0, er0, ed0, need;
        cell_t e;
        oi0 = oi; d0 = n_drd; dr0 = n_drop; er0 = exp_rd; ed0 = exp_drop;
        o_cell_ready = 1'b1;
        send_frame(16'h0001, 0);
        send_frame(16'h0401, 0);
        need = exp_q.size();
        for (int t = 0; t < 300; t++) begin
            if (obs.size() >= oi + need && d_rd == d_wr) break;
            @(posedge clk); #1;
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (obs.size() != oi + need) begin
            errors++;
            $display("FAIL zpm_count got %0d want %0d",
                     obs.size() - oi, need);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (oi >= obs.size()) begin
                errors++;
                $display("FAIL zpm_missing cell %0d", oi - oi0);
            end else if (obs[oi] !== e) begin
                errors++;
                $display("FAIL zpm_cell%0d got %h want %h",
                         oi - oi0, obs[oi], e);
            end
            oi++;
        end
        checks++;
        if (n_drop - dr0 != exp_drop - ed0) begin
            errors++;
            $display("FAIL zpm_drops got %0d want %0d",
                     n_drop - dr0, exp_drop - ed0);
        end
        checks++;
        if (n_drd - d0 != exp_rd - er0) begin
            errors++;
            $display("FAIL zpm_reads got %0d want %0d",
                     n_drd - d0, exp_rd - er0);
        end
    endtask

    task automatic test_random();
        int oi0, d0, l0, dr0, u0, er0, el0, ed0, need, sent, n, h;
        logic [15:0] d;
        cell_t e;
        oi0 = oi; d0 = n_drd; l0 = n_lerr; dr0 = n_drop; u0 = n_unstable;
        er0 = exp_rd; el0 = exp_lerr; ed0 = exp_drop; sent = 0;
        for (int t = 0; t < 1500; t++) begin
            o_cell_ready = ($urandom_range(0, 3) != 0);
            if (sent < 40 && $urandom_range(0, 3) == 0) begin
                d = 16'($urandom);
                d[5:0] = 6'($urandom_range(0, 5));
                n = int'(d[5:0]) * 4;
                h = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n) : 0;
                send_frame(d, h);
                sent++;
            end
            if ($urandom_range(0, 1) == 1) release_one();
            @(posedge clk); #1;
        end
        while (pend.size() > 0) release_one();
        o_cell_ready = 1'b1;
        need = exp_q.size();
        for (int t = 0; t < 2000; t++) begin
            if (obs.size() >= oi + need && d_rd == d_wr &&
                p_rd == p_wr) break;
            @(posedge clk); #1;
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (obs.size() != oi + need) begin
            errors++;
            $display("FAIL rand_count got %0d want %0d",
                     obs.size() - oi, need);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (oi >= obs.size()) begin
                errors++;
                $display("FAIL rand_missing cell %0d", oi - oi0);
            end else if (obs[oi] !== e) begin
                errors++;
                $display("FAIL rand_cell%0d got %h want %h",
                         oi - oi0, obs[oi], e);
            end
            oi++;
        end
        checks++;
        if (n_lerr - l0 != exp_lerr - el0 ||
            n_drop - dr0 != exp_drop - ed0) begin
            errors++;
            $display("FAIL rand_pulses got lerr %0d drop %0d want %0d %0d",
                     n_lerr - l0, n_drop - dr0,
                     exp_lerr - el0, exp_drop - ed0);
        end
        checks++;
        if (n_drd - d0 != exp_rd - er0) begin
            errors++;
            $display("FAIL rand_reads got %0d want %0d",
                     n_drd - d0, exp_rd - er0);
        end
        checks++;
        if (n_unstable != u0) begin
            errors++;
            $display("FAIL rand_stable got %0d changes want 0",
                     n_unstable - u0);
        end
        checks++;
        if (bad_prd != 0 || bad_drd != 0) begin
            errors++;
            $display("FAIL rd_when_empty got ptr %0d data %0d want 0 0",
                     bad_prd, bad_drd);
        end
    endtask

    task automatic test_reset_mid();
        int oi0, need;
        cell_t e;
        o_cell_ready = 1'b0;
        send_frame(16'h0302, 0);
        send_frame(16'h0401, 0);
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (o_cell_valid !== 1'b1 || ptr_fifo_empty !== 1'b0) begin
            errors++;
            $display("FAIL rmid_setup got valid %b pempty %b want 1 0",
                     o_cell_valid, ptr_fifo_empty);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({o_cell_valid, o_cell_sop, o_cell_eop, o_cell_portmap,
             ptr_fifo_rd, data_fifo_rd, o_len_err, o_drop} !== 11'd0 ||
            o_cell_data !== '0) begin
            errors++;
            $display("FAIL rmid_outputs got v%b s%b e%b pm%h pr%b dr%b d%h want 0",
                     o_cell_valid, o_cell_sop, o_cell_eop, o_cell_portmap,
                     ptr_fifo_rd, data_fifo_rd, o_cell_data);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
        pend.delete();
        oi = obs.size();
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        oi0 = oi;
        o_cell_ready = 1'b1;
        send_frame(16'h0901, 0);
        need = exp_q.size();
        for (int t = 0; t < 200; t++) begin
            if (obs.size() >= oi + need) break;
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (obs.size() != oi + need) begin
            errors++;
            $display("FAIL rmid_count got %0d want %0d",
                     obs.size() - oi, need);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (oi >= obs.size()) begin
                errors++;
                $display("FAIL rmid_missing cell %0d", oi - oi0);
            end else if (obs[oi] !== e) begin
                errors++;
                $display("FAIL rmid_cell%0d got %h want %h",
                         oi - oi0, obs[oi], e);
            end
            oi++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_len_err();
        test_stall();
        test_zero_portmap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
